// File: rtl/error_calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : error_calc_pkg
// Description : Shared constants, FSM encoding and helpers for the
//               ReLU / error_calc / backprop training stages.
// Revision    : 1.0 - initial release
// ============================================================================
package error_calc_pkg;

    localparam int CLASSIFICATIONS = 10;
    localparam int NORMALIZED_SIZE = 25;
    localparam int ERROR_SIZE      = NORMALIZED_SIZE + 1;
    localparam int SUM_SIZE        = 30;
    localparam int IDX_W           = $clog2(CLASSIFICATIONS);

    localparam logic [NORMALIZED_SIZE-1:0] TARGET_ONE = 25'h1000000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } calc_state_t;

    typedef logic [CLASSIFICATIONS-1:0][NORMALIZED_SIZE-1:0] norm_vec_t;
    typedef logic [CLASSIFICATIONS-1:0][ERROR_SIZE-1:0]      err_vec_t;

    // True only when exactly one bit is set.
    function automatic logic is_onehot(input logic [CLASSIFICATIONS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage : error_calc_pkg
`default_nettype wire

// File: rtl/error_calc_if.sv
`default_nettype none
// ============================================================================
// Module      : error_calc_if
// Description : Bus between the normalize stage (master) and error_calc
//               (slave), including the error results handed to backprop.
// Revision    : 1.0 - initial release
// ============================================================================
interface error_calc_if;
    import error_calc_pkg::*;

    logic                                         en;
    logic [CLASSIFICATIONS*NORMALIZED_SIZE-1:0]   normalized_results;
    logic [CLASSIFICATIONS-1:0]                   class_hotcoded;
    logic [CLASSIFICATIONS-1:0]                   label;
    logic [CLASSIFICATIONS*ERROR_SIZE-1:0]        error_vector;
    logic [SUM_SIZE-1:0]                          abs_error_sum;
    logic                                         correct;
    logic                                         label_err;
    logic                                         done;

    modport master (
        output en, normalized_results, class_hotcoded, label,
        input  error_vector, abs_error_sum, correct, label_err, done
    );

    modport slave (
        input  en, normalized_results, class_hotcoded, label,
        output error_vector, abs_error_sum, correct, label_err, done
    );

endinterface : error_calc_if
`default_nettype wire

// File: rtl/error_element.sv
`default_nettype none
// ============================================================================
// Module      : error_element
// Description : Target select, signed error and magnitude for one class.
// Revision    : 1.0 - initial release
// ============================================================================
module error_element
    import error_calc_pkg::*;
(
    input  wire logic [NORMALIZED_SIZE-1:0] norm_i,
    input  wire logic                       label_bit_i,
    input  wire logic                       label_err_i,
    output logic      [ERROR_SIZE-1:0]      err_o,
    output logic      [ERROR_SIZE-1:0]      abs_o
);

    logic [NORMALIZED_SIZE-1:0] target_w;

    always_comb begin
        target_w = (label_bit_i && !label_err_i) ? TARGET_ONE : '0;
        // One guard bit makes the difference of two unsigned values exact.
        err_o    = {1'b0, target_w} - {1'b0, norm_i};
        abs_o    = err_o[ERROR_SIZE-1] ? (~err_o + 1'b1) : err_o;
    end

endmodule : error_element
`default_nettype wire

// File: rtl/error_calc.sv
`default_nettype none
// ============================================================================
// Module      : error_calc
// Description : Serial per-class loss stage: latches outputs/label, produces
//               signed errors, absolute-error sum and correctness flag.
// Revision    : 1.0 - initial release
// ============================================================================
module error_calc
    import error_calc_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst,
    error_calc_if.slave calc_if
);

    calc_state_t                 state_q;
    logic [IDX_W-1:0]            idx_q;
    norm_vec_t                   norm_q;
    logic [CLASSIFICATIONS-1:0]  class_q;
    logic [CLASSIFICATIONS-1:0]  label_q;
    err_vec_t                    err_vec_q;
    logic [SUM_SIZE-1:0]         acc_q;
    logic [SUM_SIZE-1:0]         acc_d;
    logic [SUM_SIZE-1:0]         abs_sum_q;
    logic                        correct_q;
    logic                        label_err_q;
    logic                        done_q;

    logic [ERROR_SIZE-1:0]       elem_err_w;
    logic [ERROR_SIZE-1:0]       elem_abs_w;

    error_element u_element (
        .norm_i      (norm_q[idx_q]),
        .label_bit_i (label_q[idx_q]),
        .label_err_i (label_err_q),
        .err_o       (elem_err_w),
        .abs_o       (elem_abs_w)
    );

    always_comb begin
        acc_d = acc_q + {{(SUM_SIZE-ERROR_SIZE){1'b0}}, elem_abs_w};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            norm_q      <= '0;
            class_q     <= '0;
            label_q     <= '0;
            err_vec_q   <= '0;
            acc_q       <= '0;
            abs_sum_q   <= '0;
            correct_q   <= 1'b0;
            label_err_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (calc_if.en) begin
                        norm_q      <= calc_if.normalized_results;
                        class_q     <= calc_if.class_hotcoded;
                        label_q     <= calc_if.label;
                        label_err_q <= !is_onehot(calc_if.label);
                        err_vec_q   <= '0;
                        acc_q       <= '0;
                        idx_q       <= '0;
                        state_q     <= S_CALC;
                    end
                end
                S_CALC: begin
                    err_vec_q[idx_q] <= elem_err_w;
                    acc_q            <= acc_d;
                    if (idx_q == IDX_W'(CLASSIFICATIONS - 1)) begin
                        abs_sum_q <= acc_d;
                        correct_q <= (class_q == label_q) && !label_err_q;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    // Results stay put after done drops; only a new run clears them.
                    if (!calc_if.en) begin
                        done_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign calc_if.error_vector  = err_vec_q;
    assign calc_if.abs_error_sum = abs_sum_q;
    assign calc_if.correct       = correct_q;
    assign calc_if.label_err     = label_err_q;
    assign calc_if.done          = done_q;

endmodule : error_calc
`default_nettype wire

// File: tb/tb_error_calc.sv
`default_nettype none
// ============================================================================
// Module      : tb_error_calc
// Description : Self-checking bench for error_calc against a behavioural
//               loss model, with fixed and randomized runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_error_calc;
    import error_calc_pkg::*;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    error_calc_if bus ();

    error_calc dut (
        .clk     (clk),
        .rst     (rst),
        .calc_if (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference: target is 2^24 for the labelled class of a valid label,
    // error = target - norm, sum of magnitudes, correct only with a valid label.
    task automatic model(input norm_vec_t n, input logic [9:0] c, input logic [9:0] l,
                         output err_vec_t ev, output logic [29:0] s,
                         output logic cr, output logic le);
        longint acc;
        longint t;
        longint e;
        le  = ($countones(l) != 1);
        acc = 0;
        for (int i = 0; i < CLASSIFICATIONS; i++) begin
            t = (!le && l[i]) ? 64'sd16777216 : 64'sd0;
            e = t - longint'(n[i]);
            ev[i] = e[25:0];
            acc += (e < 0) ? -e : e;
        end
        s  = acc[29:0];
        cr = !le && (c == l);
    endtask

    task automatic drive_random_bus();
        norm_vec_t r;
        for (int i = 0; i < CLASSIFICATIONS; i++) r[i] = 25'($urandom);
        bus.normalized_results = r;
        bus.class_hotcoded     = 10'($urandom);
        bus.label              = 10'($urandom);
        bus.en                 = 1'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_vec"},  64'(bus.error_vector == '0), 64'd1);
        chk({tag, "_sum"},  64'(bus.abs_error_sum), 64'd0);
        chk({tag, "_cor"},  64'(bus.correct), 64'd0);
        chk({tag, "_lerr"}, 64'(bus.label_err), 64'd0);
        chk({tag, "_done"}, 64'(bus.done), 64'd0);
    endtask

    // One full run from IDLE; checks every cycle from the latch edge to the return to IDLE.
    task automatic do_run(input string tag, input norm_vec_t n, input logic [9:0] c,
                          input logic [9:0] l, input bit toggle, input int hold);
        err_vec_t    ev;
        err_vec_t    dv;
        logic [29:0] s;
        logic        cr;
        logic        le;
        model(n, c, l, ev, s, cr, le);
        @(negedge clk);
        bus.normalized_results = n;
        bus.class_hotcoded     = c;
        bus.label              = l;
        bus.en                 = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_lerr_e0"}, 64'(bus.label_err), 64'(le));
        chk({tag, "_done_e0"}, 64'(bus.done), 64'd0);
        for (int k = 1; k <= CLASSIFICATIONS; k++) begin
            if (toggle) begin
                @(negedge clk);
                drive_random_bus();
            end
            @(posedge clk); #1;
            dv = bus.error_vector;
            chk($sformatf("%s_err%0d", tag, k - 1), 64'(dv[k-1]), 64'(ev[k-1]));
            chk($sformatf("%s_done_e%0d", tag, k), 64'(bus.done), 64'(k == CLASSIFICATIONS));
        end
        chk({tag, "_vec"},  64'(bus.error_vector == ev), 64'd1);
        chk({tag, "_sum"},  64'(bus.abs_error_sum), 64'(s));
        chk({tag, "_cor"},  64'(bus.correct), 64'(cr));
        chk({tag, "_lerr"}, 64'(bus.label_err), 64'(le));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            bus.en = 1'b1;
            @(posedge clk); #1;
            chk({tag, "_hold_done"}, 64'(bus.done), 64'd1);
            chk({tag, "_hold_vec"},  64'(bus.error_vector == ev), 64'd1);
        end
        @(negedge clk);
        bus.en = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_rel_done"}, 64'(bus.done), 64'd0);
        chk({tag, "_rel_vec"},  64'(bus.error_vector == ev), 64'd1);
        chk({tag, "_rel_sum"},  64'(bus.abs_error_sum), 64'(s));
        chk({tag, "_rel_cor"},  64'(bus.correct), 64'(cr));
    endtask

    initial begin
        norm_vec_t   n;
        err_vec_t    dv;
        logic [9:0]  lbl;
        logic [9:0]  cls;
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        bus.en  = 1'b0;
        bus.normalized_results = '0;
        bus.class_hotcoded     = '0;
        bus.label              = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Perfect prediction of class 3.
        n = '0; n[3] = 25'h1000000;
        do_run("perfect", n, 10'b0000001000, 10'b0000001000, 1'b0, 0);
        chk("perfect_lit_vec", 64'(bus.error_vector == '0), 64'd1);
        chk("perfect_lit_cor", 64'(bus.correct), 64'd1);

        // Mixed signs, wrong prediction.
        n = '0; n[0] = 25'h0800000; n[5] = 25'h0400000;
        do_run("mixed", n, 10'b0000100000, 10'b0000000001, 1'b0, 2);
        dv = bus.error_vector;
        chk("mixed_lit_err0", 64'(dv[0]), 64'h0800000);
        chk("mixed_lit_err5", 64'(dv[5]), 64'h3C00000);
        chk("mixed_lit_sum",  64'(bus.abs_error_sum), 64'h0C00000);
        chk("mixed_lit_cor",  64'(bus.correct), 64'd0);

        // Saturated outputs exercise the full accumulator width.
        for (int i = 0; i < CLASSIFICATIONS; i++) n[i] = 25'h1FFFFFF;
        do_run("maxnorm", n, 10'b1000000000, 10'b1000000000, 1'b0, 0);
        dv = bus.error_vector;
        chk("maxnorm_lit_err9", 64'(dv[9]), 64'h3000001);
        chk("maxnorm_lit_err0", 64'(dv[0]), 64'h2000001);
        chk("maxnorm_lit_sum",  64'(bus.abs_error_sum), 64'h12FFFFF6);

        // Invalid labels: zero and two bits set.
        for (int i = 0; i < CLASSIFICATIONS; i++) n[i] = 25'(i * 25'h0123457 + 5);
        do_run("lbl_zero", n, 10'b0000000001, 10'b0000000000, 1'b0, 0);
        chk("lbl_zero_lit_lerr", 64'(bus.label_err), 64'd1);
        do_run("lbl_two", n, 10'b0000100001, 10'b0000100001, 1'b0, 1);
        chk("lbl_two_lit_cor", 64'(bus.correct), 64'd0);

        // Reset in the middle of a run, then rerun the same data.
        n[2] = 25'h1000000;
        @(negedge clk);
        bus.normalized_results = n;
        bus.class_hotcoded     = 10'b0000000100;
        bus.label              = 10'b0000000100;
        bus.en                 = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst    = 1'b1;
        bus.en = 1'b0;
        @(posedge clk); #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_idle_done", 64'(bus.done), 64'd0);
        do_run("rerun", n, 10'b0000000100, 10'b0000000100, 1'b0, 0);

        // Randomized runs; some toggle every input during CALC.
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < CLASSIFICATIONS; i++) n[i] = 25'($urandom);
            lbl = 10'b1 << $urandom_range(9, 0);
            if ($urandom_range(3, 0) == 0) lbl = 10'($urandom);
            cls = ($urandom_range(1, 0) == 0) ? lbl : (10'b1 << $urandom_range(9, 0));
            if ($urandom_range(1, 0) == 0) n[$urandom_range(9, 0)] = 25'h1000000;
            do_run($sformatf("rand%0d", r), n, cls, lbl, r[0], int'($urandom_range(2, 0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_error_calc
`default_nettype wire
